// File: rtl/vga_layer_mixer.sv
// Pixel compositor: fixed-priority object layers over a programmable background,
// two-stage pipeline with matching sync delay and a frame-counted win-flash FSM.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | normal composition, waiting for a win edge
// FLASH_ON  | every visible pixel shows the winner's paddle colour
// FLASH_OFF | normal composition between flash half-periods
module vga_layer_mixer #(
    parameter int N_OBJ         = 3,
    parameter int CW            = 4,
    parameter int FLASH_PERIOD  = 8,
    parameter int FLASH_COUNT   = 6,
    parameter int VS_ACTIVE_LOW = 1
) (
    input  logic                         vga_clk,
    input  logic                         rst,
    input  logic                         hs_in,
    input  logic                         vs_in,
    input  logic                         disparea,
    input  logic [N_OBJ-1:0]             obj_hit,
    input  logic                         p1_win,
    input  logic                         p2_win,
    input  logic                         cfg_we,
    input  logic [$clog2(N_OBJ+1)-1:0]   cfg_idx,
    input  logic [3*CW-1:0]              cfg_rgb,
    output logic                         hs_out,
    output logic                         vs_out,
    output logic [CW-1:0]                vga_r,
    output logic [CW-1:0]                vga_g,
    output logic [CW-1:0]                vga_b,
    output logic                         flash_active
);

    localparam int IDX_W = $clog2(N_OBJ + 1);
    localparam int FP_W  = $clog2(FLASH_PERIOD + 1);
    localparam int FC_W  = $clog2(FLASH_COUNT + 1);
    localparam int RGB_W = 3 * CW;
    localparam logic SYNC_OFF = (VS_ACTIVE_LOW != 0);
    localparam logic [FP_W-1:0] FP_END = FP_W'(FLASH_PERIOD);
    localparam logic [FC_W-1:0] FC_END = FC_W'(FLASH_COUNT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLASH_ON  = 2'd1,
        FLASH_OFF = 2'd2
    } state_t;

    function automatic logic [RGB_W-1:0] col_reset(input int i);
        if (i == N_OBJ) return '0;
        case (i)
            0:       return {{CW{1'b1}}, {(2*CW){1'b0}}};
            1:       return {{CW{1'b0}}, {CW{1'b1}}, {CW{1'b0}}};
            2:       return {{(2*CW){1'b0}}, {CW{1'b1}}};
            default: return '1;
        endcase
    endfunction

    logic                hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d, de_s1_q, de_s1_d;
    logic [N_OBJ-1:0]    hit_s1_q, hit_s1_d;
    logic                p1_q, p1_d, p2_q, p2_d;
    logic                hs_out_q, hs_out_d, vs_out_q, vs_out_d;
    logic [RGB_W-1:0]    rgb_q, rgb_d;
    logic                flash_q, flash_d;
    state_t              state_q, state_d;
    logic                winner_q, winner_d;
    logic [FP_W-1:0]     frame_q, frame_d;
    logic [FC_W-1:0]     half_q, half_d;
    logic [RGB_W-1:0]    col_q [N_OBJ+1];
    logic [RGB_W-1:0]    col_d [N_OBJ+1];
    logic [RGB_W-1:0]    sel;
    logic                frame_tick, p1_edge, p2_edge;

    always_comb begin
        hs_s1_d  = hs_in;
        vs_s1_d  = vs_in;
        de_s1_d  = disparea;
        hit_s1_d = obj_hit;
        p1_d     = p1_win;
        p2_d     = p2_win;
        hs_out_d = hs_s1_q;
        vs_out_d = vs_s1_q;

        // vs_out_q is the previous stage-1 vs, so this fires on the assertion edge.
        frame_tick = (vs_s1_q != SYNC_OFF) && (vs_out_q == SYNC_OFF);
        p1_edge    = p1_win & ~p1_q;
        p2_edge    = p2_win & ~p2_q;

        col_d = col_q;
        for (int i = 0; i <= N_OBJ; i++) begin
            if (cfg_we && (cfg_idx == IDX_W'(i))) col_d[i] = cfg_rgb;
        end

        state_d  = state_q;
        winner_d = winner_q;
        frame_d  = frame_q;
        half_d   = half_q;
        case (state_q)
            IDLE: begin
                if (p1_edge || p2_edge) begin
                    winner_d = ~p1_edge;
                    frame_d  = '0;
                    half_d   = '0;
                    state_d  = FLASH_ON;
                end
            end
            FLASH_ON, FLASH_OFF: begin
                if (frame_tick) begin
                    if (frame_q + 1'b1 == FP_END) begin
                        frame_d = '0;
                        half_d  = half_q + 1'b1;
                        if (half_q + 1'b1 == FC_END) state_d = IDLE;
                        else state_d = (state_q == FLASH_ON) ? FLASH_OFF : FLASH_ON;
                    end else begin
                        frame_d = frame_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        flash_d = (state_d != IDLE);

        sel = col_q[N_OBJ];
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (hit_s1_q[i]) sel = col_q[i];
        end
        rgb_d = '0;
        if (de_s1_q) begin
            if (state_q == FLASH_ON) rgb_d = winner_q ? col_q[2] : col_q[1];
            else rgb_d = sel;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            hs_s1_q  <= SYNC_OFF;
            vs_s1_q  <= SYNC_OFF;
            de_s1_q  <= 1'b0;
            hit_s1_q <= '0;
            p1_q     <= 1'b0;
            p2_q     <= 1'b0;
            hs_out_q <= SYNC_OFF;
            vs_out_q <= SYNC_OFF;
            rgb_q    <= '0;
            flash_q  <= 1'b0;
            state_q  <= IDLE;
            winner_q <= 1'b0;
            frame_q  <= '0;
            half_q   <= '0;
            for (int i = 0; i <= N_OBJ; i++) col_q[i] <= col_reset(i);
        end else begin
            hs_s1_q  <= hs_s1_d;
            vs_s1_q  <= vs_s1_d;
            de_s1_q  <= de_s1_d;
            hit_s1_q <= hit_s1_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            hs_out_q <= hs_out_d;
            vs_out_q <= vs_out_d;
            rgb_q    <= rgb_d;
            flash_q  <= flash_d;
            state_q  <= state_d;
            winner_q <= winner_d;
            frame_q  <= frame_d;
            half_q   <= half_d;
            col_q    <= col_d;
        end
    end

    assign hs_out       = hs_out_q;
    assign vs_out       = vs_out_q;
    assign vga_r        = rgb_q[RGB_W-1 -: CW];
    assign vga_g        = rgb_q[2*CW-1 -: CW];
    assign vga_b        = rgb_q[CW-1:0];
    assign flash_active = flash_q;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Bench for vga_layer_mixer: directed steps plus randomized traffic, checked
// against a frame/tick-count model of the compositor and flash sequence.
module tb_vga_layer_mixer;
    localparam int N_OBJ = 4;
    localparam int CW    = 4;
    localparam int FP    = 2;
    localparam int FC    = 2;

    logic              vga_clk = 1'b0;
    logic              rst, hs_in, vs_in, disparea;
    logic [N_OBJ-1:0]  obj_hit;
    logic              p1_win, p2_win, cfg_we;
    logic [2:0]        cfg_idx;
    logic [11:0]       cfg_rgb;
    logic              hs_out, vs_out, flash_active;
    logic [CW-1:0]     vga_r, vga_g, vga_b;

    vga_layer_mixer #(
        .N_OBJ(N_OBJ), .CW(CW), .FLASH_PERIOD(FP), .FLASH_COUNT(FC), .VS_ACTIVE_LOW(1)
    ) dut (
        .vga_clk(vga_clk), .rst(rst), .hs_in(hs_in), .vs_in(vs_in), .disparea(disparea),
        .obj_hit(obj_hit), .p1_win(p1_win), .p2_win(p2_win), .cfg_we(cfg_we),
        .cfg_idx(cfg_idx), .cfg_rgb(cfg_rgb), .hs_out(hs_out), .vs_out(vs_out),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .flash_active(flash_active)
    );

    always #5 vga_clk = ~vga_clk;

    int checks = 0;
    int failures = 0;

    // Model: colour table, flash activity counted in frame ticks since the win.
    logic [11:0]      m_col [N_OBJ+1];
    bit               m_active;
    int               m_winner;
    int               m_ticks;
    logic             h_hs1, h_vs1, h_de1, h_vs2, h_p1, h_p2;
    logic [N_OBJ-1:0] h_hit1;
    logic [11:0]      e_rgb;
    logic             e_hs, e_vs, e_fa;
    int               span;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] prio(input logic [N_OBJ-1:0] hit);
        for (int i = 0; i < N_OBJ; i++) if (hit[i]) return m_col[i];
        return m_col[N_OBJ];
    endfunction

    task automatic model_reset();
        m_col[0] = 12'hF00; m_col[1] = 12'h0F0; m_col[2] = 12'h00F;
        m_col[3] = 12'hFFF; m_col[4] = 12'h000;
        m_active = 0; m_ticks = 0; m_winner = 1;
        h_hs1 = 1; h_vs1 = 1; h_de1 = 0; h_hit1 = '0; h_vs2 = 1; h_p1 = 0; h_p2 = 0;
    endtask

    task automatic cycle(input string tag);
        bit prev_fa, tick, flash_on;
        prev_fa = flash_active;
        @(posedge vga_clk);
        if (rst) begin
            model_reset();
            e_rgb = '0; e_hs = 1; e_vs = 1; e_fa = 0;
        end else begin
            tick     = !h_vs1 && h_vs2;
            flash_on = m_active && ((m_ticks / FP) % 2 == 0);
            e_rgb    = !h_de1 ? 12'h000 : (flash_on ? m_col[m_winner] : prio(h_hit1));
            e_hs     = h_hs1;
            e_vs     = h_vs1;
            if (tick && prev_fa) span++;
            if (cfg_we && int'(cfg_idx) <= N_OBJ) m_col[cfg_idx] = cfg_rgb;
            if (!m_active) begin
                if ((p1_win && !h_p1) || (p2_win && !h_p2)) begin
                    m_active = 1;
                    m_winner = (p1_win && !h_p1) ? 1 : 2;
                    m_ticks  = 0;
                end
            end else if (tick) begin
                m_ticks++;
                if (m_ticks >= FP * FC) m_active = 0;
            end
            e_fa  = m_active;
            h_vs2 = h_vs1;
            h_hs1 = hs_in; h_vs1 = vs_in; h_de1 = disparea; h_hit1 = obj_hit;
            h_p1  = p1_win; h_p2 = p2_win;
        end
        @(negedge vga_clk);
        chk({tag, "_rgb"},   32'({vga_r, vga_g, vga_b}), 32'(e_rgb));
        chk({tag, "_hs"},    32'(hs_out), 32'(e_hs));
        chk({tag, "_vs"},    32'(vs_out), 32'(e_vs));
        chk({tag, "_flash"}, 32'(flash_active), 32'(e_fa));
    endtask

    task automatic frame(input string tag, input int lines, input int width, input int wr_pct);
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < width; p++) begin
                hs_in = 1; vs_in = 1; disparea = 1;
                obj_hit = N_OBJ'($urandom);
                cfg_we  = ($urandom_range(99) < wr_pct);
                cfg_idx = 3'($urandom);
                cfg_rgb = 12'($urandom);
                cycle(tag);
            end
            cfg_we = 0; disparea = 0; hs_in = 0;
            cycle(tag); cycle(tag);
            hs_in = 1;
            cycle(tag);
        end
        vs_in = 0;
        repeat (3) cycle(tag);
        vs_in = 1;
        repeat (2) cycle(tag);
    endtask

    initial begin
        rst = 1; hs_in = 1; vs_in = 1; disparea = 0; obj_hit = '0;
        p1_win = 0; p2_win = 0; cfg_we = 0; cfg_idx = '0; cfg_rgb = '0;
        model_reset();
        cycle("reset"); cycle("reset");
        rst = 0;
        chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
        chk("rst_hs", 32'(hs_out), 32'h1);
        chk("rst_vs", 32'(vs_out), 32'h1);
        chk("rst_flash", 32'(flash_active), 32'h0);

        disparea = 1; obj_hit = 4'b0110;
        cycle("green"); cycle("green");
        chk("green_pix", 32'({vga_r, vga_g, vga_b}), 32'h0F0);
        obj_hit = '0;
        cycle("black"); cycle("black");
        chk("black_pix", 32'({vga_r, vga_g, vga_b}), 32'h000);

        cfg_we = 1; cfg_idx = 3'd4; cfg_rgb = 12'h123;
        cycle("bg_wr");
        cfg_we = 0;
        cycle("bg_wr");
        chk("bg_pix", 32'({vga_r, vga_g, vga_b}), 32'h123);
        cfg_we = 1; cfg_idx = 3'd7; cfg_rgb = 12'hABC;
        cycle("bad_wr");
        cfg_we = 0;
        cycle("bad_wr");
        chk("bad_idx_bg", 32'({vga_r, vga_g, vga_b}), 32'h123);
        obj_hit = 4'b1000;
        cycle("white"); cycle("white");
        chk("obj3_white", 32'({vga_r, vga_g, vga_b}), 32'hFFF);
        disparea = 0; obj_hit = '0;
        frame("pre", 2, 6, 0);

        span = 0;
        p2_win = 1;
        cycle("p2_edge");
        disparea = 1; obj_hit = 4'b0001;
        cycle("p2_on"); cycle("p2_on");
        chk("flash_blue", 32'({vga_r, vga_g, vga_b}), 32'h00F);
        disparea = 0;
        repeat (6) frame("p2_flash", 2, 6, 0);
        chk("p2_span", 32'(span), 32'(FP * FC));
        chk("p2_done", 32'(flash_active), 32'h0);
        p2_win = 0;
        cycle("p2_rel");

        span = 0;
        p1_win = 1; p2_win = 1;
        cycle("both_edge");
        disparea = 1; obj_hit = 4'b0100;
        cycle("both_on"); cycle("both_on");
        chk("flash_green", 32'({vga_r, vga_g, vga_b}), 32'h0F0);
        disparea = 0;
        frame("both_flash", 2, 6, 0);
        p2_win = 0;
        cycle("p2_pulse");
        p2_win = 1;
        cycle("p2_pulse");
        repeat (5) frame("both_flash", 2, 6, 0);
        chk("both_span", 32'(span), 32'(FP * FC));
        p1_win = 0; p2_win = 0;
        cycle("both_rel");

        p1_win = 1;
        cycle("mid_edge");
        p1_win = 0; disparea = 1; obj_hit = '0;
        cycle("mid_on"); cycle("mid_on");
        chk("mid_on_green", 32'({vga_r, vga_g, vga_b}), 32'h0F0);
        rst = 1;
        cycle("mid_rst");
        rst = 0;
        chk("mid_rst_flash", 32'(flash_active), 32'h0);
        chk("mid_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
        chk("mid_rst_hs", 32'(hs_out), 32'h1);
        chk("mid_rst_vs", 32'(vs_out), 32'h1);
        cycle("post_rst"); cycle("post_rst");
        chk("post_rst_bg", 32'({vga_r, vga_g, vga_b}), 32'h000);
        obj_hit = 4'b0001;
        cycle("post_rst"); cycle("post_rst");
        chk("post_rst_red", 32'({vga_r, vga_g, vga_b}), 32'hF00);

        repeat (3) frame("rand_frame", 3, 8, 10);

        for (int n = 0; n < 1200; n++) begin
            hs_in    = 1'($urandom_range(1));
            vs_in    = 1'($urandom_range(1));
            disparea = 1'($urandom_range(1));
            obj_hit  = N_OBJ'($urandom);
            if ($urandom_range(30) == 0) p1_win = ~p1_win;
            if ($urandom_range(30) == 0) p2_win = ~p2_win;
            cfg_we   = ($urandom_range(15) == 0);
            cfg_idx  = 3'($urandom);
            cfg_rgb  = 12'($urandom);
            rst      = ($urandom_range(300) == 0);
            cycle("rand");
        end
        rst = 0; cfg_we = 0;
        cycle("tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
